vx_mem_responder: RTL



---
 rtl/vx_mem_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: on-chip line memory that terminates one Vortex memory port.
// Byte-enabled writes land in a line-wide RAM. Reads travel through a fixed
// delay pipeline into an in-order response FIFO. A credit counter bounds the
// number of outstanding reads so the pipeline never stalls on a full FIFO.
module vx_mem_responder #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned RAM_ADDR_WIDTH = 10,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned RSP_QUEUE      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int unsigned BYTE_W    = DATA_WIDTH / 8;
  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int unsigned STAGES    = LATENCY - 1;
  localparam int unsigned PTR_W     = (RSP_QUEUE > 1) ? $clog2(RSP_QUEUE) : 1;
  localparam int unsigned CNT_W     = $clog2(RSP_QUEUE + 1);

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic                      ready_q;
  logic                      busy_q;
  logic                      rsp_valid_q;
  logic                      req_fire;
  logic                      read_fire;
  logic                      write_fire;
  logic                      rsp_fire;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      addr_unused;

  assign req_fire   = mem_req_valid & ready_q & ~reset;
  assign read_fire  = req_fire & ~mem_req_rw;
  assign write_fire = req_fire & mem_req_rw;
  assign rsp_fire   = rsp_valid_q & mem_rsp_ready;

  // Upper address bits alias onto the RAM; they are deliberately dropped.
  assign ram_idx     = mem_req_addr[RAM_ADDR_WIDTH-1:0];
  assign addr_unused = ^mem_req_addr;

  // ---------------------------------------------------------------------------
  // Line RAM (not reset; contents survive reset)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0] wr_mask;

  // Expand byte enables to a bit mask.
  for (genvar b = 0; b < BYTE_W; b++) begin : g_mask
    assign wr_mask[b*8 +: 8] = {8{mem_req_byteen[b]}};
  end

  assign rd_line = ram[ram_idx];

  // Byte-enabled write at the fire edge.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      ram[ram_idx] <= (rd_line & ~wr_mask) | (mem_req_data & wr_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Read delay pipeline: LATENCY-1 register stages between capture and FIFO
  // ---------------------------------------------------------------------------
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;

  if (STAGES == 0) begin : g_direct
    assign push_valid = read_fire;
    assign push_data  = rd_line;
    assign push_tag   = mem_req_tag;
  end else begin : g_pipe
    logic [STAGES-1:0]                 pipe_valid_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] pipe_data_q;
    logic [STAGES-1:0][TAG_WIDTH-1:0]  pipe_tag_q;

    // Valid shift register; element 0 is the capture stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_valid_q <= '0;
      end else begin
        pipe_valid_q <= STAGES'({pipe_valid_q, read_fire});
      end
    end

    // Payload shift register; qualified by the valid bits only.
    always_ff @(posedge clk) begin
      pipe_data_q <= (STAGES*DATA_WIDTH)'({pipe_data_q, rd_line});
      pipe_tag_q  <= (STAGES*TAG_WIDTH)'({pipe_tag_q, mem_req_tag});
    end

    assign push_valid = pipe_valid_q[STAGES-1];
    assign push_data  = pipe_data_q[STAGES-1];
    assign push_tag   = pipe_tag_q[STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_data [RSP_QUEUE];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_QUEUE];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic [CNT_W-1:0]      fifo_cnt_d;

  // FIFO occupancy next value.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push_valid && !rsp_fire) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push_valid && rsp_fire) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  // FIFO pointers, occupancy and registered head-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (push_valid) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rsp_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q  <= fifo_cnt_d;
      rsp_valid_q <= (fifo_cnt_d != '0);
    end
  end

  // FIFO storage; credit accounting guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_data[wr_ptr_q] <= push_data;
      fifo_tag[wr_ptr_q]  <= push_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter: reads in flight anywhere between fire and response fire
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;

  // Pending next value; simultaneous read and response fire cancel out.
  always_comb begin
    pending_d = pending_q;
    if (read_fire && !rsp_fire) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (!read_fire && rsp_fire) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  // Pending count plus registered ready/busy derived from its next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ready_q   <= (pending_d < CNT_W'(RSP_QUEUE));
      busy_q    <= (pending_d != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_ready = ready_q;
  assign busy          = busy_q;
  assign mem_rsp_valid = rsp_valid_q;
  assign mem_rsp_data  = fifo_data[rd_ptr_q];
  assign mem_rsp_tag   = fifo_tag[rd_ptr_q];

endmodule
